// File: rtl/divider_iterative_8b_if.sv
// Operand and result val/rdy streams of the iterative 8-bit divider.
// The master drives operands and the result ready; the slave is the divider.
interface divider_iterative_8b_if;
    logic       istream_val;
    logic       istream_rdy;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output istream_val, dividend, divisor, ostream_rdy,
        input  istream_rdy, ostream_val, quotient, remainder, div_by_zero
    );

    modport slave (
        input  istream_val, dividend, divisor, ostream_rdy,
        output istream_rdy, ostream_val, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_iterative_8b.sv
// 8-bit unsigned restoring divider: one trial subtraction per cycle.
// The result is held in DONE until the consumer accepts it.
module divider_iterative_8b (
    input logic clk,
    input logic rst,
    divider_iterative_8b_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] count, count_nxt;
    logic [7:0] rem_reg, rem_nxt;
    logic [7:0] quo_reg, quo_nxt;
    logic [7:0] dvsr_reg, dvsr_nxt;
    logic       dbz_reg, dbz_nxt;

    logic [8:0] shifted;
    logic [7:0] diff;
    logic       fits;

    // Only the low byte of the difference is ever kept.
    assign shifted = {rem_reg, quo_reg[7]};
    assign diff    = shifted[7:0] - dvsr_reg;
    assign fits    = shifted >= {1'b0, dvsr_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 3'd0;
            rem_reg  <= 8'd0;
            quo_reg  <= 8'd0;
            dvsr_reg <= 8'd0;
            dbz_reg  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            rem_reg  <= rem_nxt;
            quo_reg  <= quo_nxt;
            dvsr_reg <= dvsr_nxt;
            dbz_reg  <= dbz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rem_nxt   = rem_reg;
        quo_nxt   = quo_reg;
        dvsr_nxt  = dvsr_reg;
        dbz_nxt   = dbz_reg;
        unique case (state)
            IDLE: begin
                if (bus.istream_val) begin
                    rem_nxt   = 8'd0;
                    quo_nxt   = bus.dividend;
                    dvsr_nxt  = bus.divisor;
                    dbz_nxt   = (bus.divisor == 8'd0);
                    count_nxt = 3'd0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (fits) begin
                    rem_nxt = diff;
                    quo_nxt = {quo_reg[6:0], 1'b1};
                end else begin
                    rem_nxt = shifted[7:0];
                    quo_nxt = {quo_reg[6:0], 1'b0};
                end
                count_nxt = count + 3'd1;
                if (count == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                if (bus.ostream_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.istream_rdy = (state == IDLE);
    assign bus.ostream_val = (state == DONE);
    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_divider_iterative_8b.sv
// Bench for divider_iterative_8b: directed corner cases plus random
// operand pairs against plain integer division.
module tb_divider_iterative_8b;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   n_acc;
    int   n_res;

    divider_iterative_8b_if bus ();

    divider_iterative_8b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.istream_val && bus.istream_rdy) n_acc++;
            if (bus.ostream_val && bus.ostream_rdy) n_res++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_irdy"}, bus.istream_rdy, 1);
        check({tag, "_oval"}, bus.ostream_val, 0);
        check({tag, "_quo"}, bus.quotient, 0);
        check({tag, "_rem"}, bus.remainder, 0);
        check({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    // One complete transaction starting from IDLE; called at a negedge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int stall, input bit noisy, input bit full);
        int         lat;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        ez = (b == 8'd0);
        eq = ez ? 8'hFF : 8'(a / b);
        er = ez ? a : 8'(a % b);
        @(posedge clk); #1;
        bus.istream_val = 1'b1;
        bus.dividend    = a;
        bus.divisor     = b;
        bus.ostream_rdy = (stall == 0);
        @(negedge clk);
        if (full) check("irdy_idle", bus.istream_rdy, 1);
        @(posedge clk); #1;
        bus.istream_val = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (noisy) begin
                bus.istream_val = 1'($urandom_range(0, 1));
                bus.dividend    = 8'($urandom);
                bus.divisor     = 8'($urandom);
            end
            @(negedge clk);
            if (bus.ostream_val === 1'b1) break;
            if (full) check("irdy_calc", bus.istream_rdy, 0);
        end
        bus.istream_val = 1'b0;
        check("latency", lat, 8);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("dbz", bus.div_by_zero, ez);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_oval", bus.ostream_val, 1);
            check("hold_irdy", bus.istream_rdy, 0);
            check("hold_quo", bus.quotient, eq);
            check("hold_rem", bus.remainder, er);
        end
        bus.ostream_rdy = 1'b1;
        @(negedge clk);
        check("oval_after", bus.ostream_val, 0);
        check("irdy_after", bus.istream_rdy, 1);
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        n_acc           = 0;
        n_res           = 0;
        rst             = 1'b1;
        bus.istream_val = 1'b0;
        bus.dividend    = 8'd0;
        bus.divisor     = 8'd0;
        bus.ostream_rdy = 1'b1;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'd100, 8'd7, 0, 0, 1);
        run_op(8'd255, 8'd1, 0, 0, 1);
        run_op(8'd5, 8'd9, 0, 0, 1);
        run_op(8'd0, 8'd3, 0, 0, 1);
        run_op(8'd255, 8'd255, 0, 0, 1);
        run_op(8'd128, 8'd16, 0, 0, 1);
        run_op(8'd200, 8'd0, 0, 0, 1);
        run_op(8'd77, 8'd5, 6, 0, 1);

        // Abort 100/7 after four iterations with an asynchronous reset.
        @(posedge clk); #1;
        bus.istream_val = 1'b1;
        bus.dividend    = 8'd100;
        bus.divisor     = 8'd7;
        @(posedge clk); #1;
        bus.istream_val = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        run_op(8'd9, 8'd2, 0, 0, 1);

        n_acc = 0;
        n_res = 0;
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)), 1, 0);
        end
        @(negedge clk);
        check("accepts", n_acc, 1000);
        check("results", n_res, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
